// File: rtl/alu_defs.sv
// Shared ALU opcode and operand-select encodings for the ID/EX stage and the ALU.
package alu_defs;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;
  localparam logic [1:0] SRC_A_RSVD = 2'd3;

  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: newest producer (EX/MEM) wins over MEM/WB; x0 never forwarded.
module fwd_mux #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]       rf_data,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_reg_write,
  input  logic [XLEN-1:0]       mem_fwd_data,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_fwd_data,
  output logic [XLEN-1:0]       fwd_data
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == rs_addr);
    wb_hit  = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs_addr);
    if (mem_hit) begin
      fwd_data = mem_fwd_data;
    end else if (wb_hit) begin
      fwd_data = wb_fwd_data;
    end else begin
      fwd_data = rf_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding and operand selection feeding the RV32I ALU.
// Also raises a combinational load-use stall and inserts a bubble for it.
module id_ex_stage
  import alu_defs::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [3:0]            id_alu_ctrl,
  input  logic [1:0]            id_src_a_sel,
  input  logic                  id_src_b_sel,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_reg_write,
  input  logic [XLEN-1:0]       mem_fwd_data,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_fwd_data,
  output logic                  load_use_stall,
  output logic [XLEN-1:0]       operand_a,
  output logic [XLEN-1:0]       operand_b,
  output logic [3:0]            ex_alu_ctrl,
  output logic [XLEN-1:0]       ex_store_data,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic [XLEN-1:0]       ex_pc
);

  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]       imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]            alu_ctrl_q, alu_ctrl_d;
  logic [1:0]            src_a_sel_q, src_a_sel_d;
  logic                  src_b_sel_q, src_b_sel_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // Flow contract: stall holds this stage; flush and load-use both load a bubble,
  // flush taking priority over stall. load_use_stall is raised regardless of
  // stall/flush, and upstream is responsible for masking it while holding IF/ID.
  always_comb begin
    load_use_stall = valid_q && mem_read_q && (rd_addr_q != '0) && id_valid &&
                     ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr));
  end

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    alu_ctrl_d  = alu_ctrl_q;
    src_a_sel_d = src_a_sel_q;
    src_b_sel_d = src_b_sel_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (flush || (!stall && load_use_stall)) begin
      valid_d     = 1'b0;
      pc_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      rs1_addr_d  = '0;
      rs2_addr_d  = '0;
      rd_addr_d   = '0;
      alu_ctrl_d  = ALU_ADD;
      src_a_sel_d = SRC_A_RS1;
      src_b_sel_d = SRC_B_RS2;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (!stall) begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      rs1_addr_d  = id_rs1_addr;
      rs2_addr_d  = id_rs2_addr;
      rd_addr_d   = id_rd_addr;
      alu_ctrl_d  = id_alu_ctrl;
      src_a_sel_d = id_src_a_sel;
      src_b_sel_d = id_src_b_sel;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      alu_ctrl_q  <= ALU_ADD;
      src_a_sel_q <= SRC_A_RS1;
      src_b_sel_q <= SRC_B_RS2;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      alu_ctrl_q  <= alu_ctrl_d;
      src_a_sel_q <= src_a_sel_d;
      src_b_sel_q <= src_b_sel_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Forwarding runs off the registered sources every cycle, so a held instruction
  // still picks up producer results that arrive while it is stalled.
  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs_addr       (rs1_addr_q),
    .rf_data       (rs1_data_q),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .mem_fwd_data  (mem_fwd_data),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_fwd_data   (wb_fwd_data),
    .fwd_data      (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs_addr       (rs2_addr_q),
    .rf_data       (rs2_data_q),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .mem_fwd_data  (mem_fwd_data),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_fwd_data   (wb_fwd_data),
    .fwd_data      (rs2_fwd)
  );

  always_comb begin
    case (src_a_sel_q)
      SRC_A_RS1: operand_a = rs1_fwd;
      SRC_A_PC:  operand_a = pc_q;
      default:   operand_a = '0;
    endcase
    operand_b     = (src_b_sel_q == SRC_B_IMM) ? imm_q : rs2_fwd;
    ex_store_data = rs2_fwd;
    ex_alu_ctrl   = alu_ctrl_q;
    ex_valid      = valid_q;
    ex_reg_write  = reg_write_q;
    ex_mem_read   = mem_read_q;
    ex_mem_write  = mem_write_q;
    ex_rd_addr    = rd_addr_q;
    ex_pc         = pc_q;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-selection stage directly upstream of the RV32I ALU.
- Captures decoded instruction fields and applies EX/MEM and MEM/WB forwarding.
- Drives the ALU's operand_a, operand_b and alu_ctrl.
- Detects load-use hazards, inserts a bubble on a load-use hazard, and honours pipeline stall and flush.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all stage registers (downstream stall)
- flush  in  1  replace the captured instruction with a bubble (branch or jump taken)
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_ADDR_W  register indices
- id_alu_ctrl  in  4  ALU opcode
- id_src_a_sel  in  2  0 = rs1, 1 = PC, 2 = zero (LUI), 3 = reserved (treated as zero)
- id_src_b_sel  in  1  0 = rs2, 1 = imm
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- mem_rd_addr  in  REG_ADDR_W  EX/MEM destination register
- mem_reg_write  in  1  EX/MEM writes a register
- mem_fwd_data  in  XLEN  EX/MEM forwardable result
- wb_rd_addr, wb_reg_write, wb_fwd_data  in  same widths  MEM/WB equivalents
- load_use_stall  out  1  combinational; upstream must hold IF and ID
- operand_a, operand_b  out  XLEN  to the ALU
- ex_alu_ctrl  out  4  to the ALU
- ex_store_data  out  XLEN  forwarded rs2 value, for stores
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control bits
- ex_rd_addr  out  REG_ADDR_W  registered destination register
- ex_pc  out  XLEN  registered PC

Behaviour:
- Bubble definition:
  - valid, reg_write, mem_read and mem_write = 0.
  - alu_ctrl = ADD (0000).
  - rd, rs1 and rs2 addresses = 0.
  - pc, rs1_data, rs2_data and imm = 0.
  - src_a_sel = 0 and src_b_sel = 0.
- Reset: every stage register takes its bubble value. With all data fields zero, operand_a = operand_b = 0 after reset.
- Per-edge update priority:
  - rst: load bubble.
  - else flush: load bubble.
  - else stall: hold the current contents.
  - else load_use_stall: load bubble.
  - else: capture the id_* inputs.
- load_use_stall = ex_valid & ex_mem_read & (ex_rd_addr != 0) & id_valid & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr). Compared against the registered EX fields. Asserts even while stall or flush is high; upstream gates it.
- Latency: an instruction captured at edge N has its ALU operands valid combinationally during cycle N+1.
- Forwarding (combinational, applied separately to the registered rs1 and to rs2):
  - If mem_reg_write & mem_rd_addr != 0 & mem_rd_addr == rs: use mem_fwd_data.
  - Else if the same test holds on the wb_* fields: use wb_fwd_data.
  - Else use the registered register-file data.
  - MEM has priority over WB when both match.
  - x0 is never forwarded.
- operand_a:
  - sel 0: forwarded rs1.
  - sel 1: ex_pc.
  - sel 2: 0.
  - sel 3: 0.
- operand_b:
  - sel 0: forwarded rs2.
  - sel 1: ex_imm.
- ex_store_data is always the forwarded rs2, whatever src_b_sel is.
- Forwarding is recomputed every cycle, including while the stage is stalled, so late-arriving producer data is picked up.
- Reset mid-stall takes effect on the next edge. The held instruction is lost.

Decomposition:
- Shared package/include alu_defs holds:
  - ALU opcode constants: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
  - SRC_A_* and SRC_B_* select encodings.
- Sub-module fwd_mux: one instance per source operand.
  - Inputs: rs address, register-file data, mem/wb triplets.
  - Output: forwarded value.

Test Plan:
- Reset: rst = 1 for 2 cycles → ex_valid = 0, ex_alu_ctrl = 0000, operand_a = operand_b = 0, load_use_stall = 0.
- Plain capture:
  - Stimulus: id rs1_data = 15, rs2_data = 10, alu_ctrl = 0001, src_b_sel = 0, no forwards.
  - Response: next cycle operand_a = 15, operand_b = 10, ex_alu_ctrl = 0001.
- Forward priority:
  - Stimulus: EX holds rs1 = x5; mem_rd_addr = 5 with mem_fwd_data = 0x80000000; wb_rd_addr = 5 with wb_fwd_data = 0x1.
  - Response: operand_a = 0x80000000.
  - Then drop mem_reg_write → operand_a = 0x1.
  - Then set mem_rd_addr = wb_rd_addr = 0 → register-file value.
- Load-use:
  - Stimulus: EX holds lw x7 (mem_read = 1, rd = 7); ID holds an instruction with rs2 = 7.
  - Response: load_use_stall = 1. Next edge ex_valid = 0. The following edge captures the held instruction, with wb forwarding of 0x1234 giving operand_b = 0x1234.
- Stall vs flush:
  - Stimulus: stall = 1 for 3 cycles while the id_* inputs change.
  - Response: EX outputs are unchanged.
  - Then stall = 1 and flush = 1 together → bubble on the next edge (flush wins).
- Immediate/PC select:
  - Stimulus: src_a_sel = 1 with pc = 0x100, src_b_sel = 1 with imm = 0xFFFFFFFC.
  - Response: operand_a = 0x100, operand_b = 0xFFFFFFFC.
  - Then src_a_sel = 2 → operand_a = 0.
